// File: rtl/mem_access_pkg.sv
// Shared constants, state encoding and store-lane helpers for the MEM stage.
package mem_access_pkg;

    localparam logic [7:0] AluNop = 8'h00;
    localparam logic [7:0] AluLb  = 8'hE0;
    localparam logic [7:0] AluLbu = 8'hE4;
    localparam logic [7:0] AluLh  = 8'hE1;
    localparam logic [7:0] AluLhu = 8'hE5;
    localparam logic [7:0] AluLw  = 8'hE3;
    localparam logic [7:0] AluLl  = 8'hF0;
    localparam logic [7:0] AluSb  = 8'hE8;
    localparam logic [7:0] AluSh  = 8'hE9;
    localparam logic [7:0] AluSw  = 8'hEB;
    localparam logic [7:0] AluSc  = 8'hF8;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NopRegAddr   = 5'd0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {AluLb, AluLbu, AluLh, AluLhu, AluLw, AluLl};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {AluSb, AluSh, AluSw, AluSc};
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lo);
        case (op)
            AluLh, AluLhu, AluSh:       return lo[0];
            AluLw, AluLl, AluSw, AluSc: return lo != 2'b00;
            default:                    return 1'b0;
        endcase
    endfunction

    // Big-endian lanes: byte address 0 lives in bits 31:24.
    function automatic logic [3:0] store_sel(input logic [7:0] op, input logic [1:0] lo);
        case (op)
            AluSb:   return 4'b1000 >> lo;
            AluSh:   return lo[1] ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [7:0] op, input logic [31:0] d);
        case (op)
            AluSb:   return {4{d[7:0]}};
            AluSh:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus request/acknowledge bundle between the MEM stage and the memory port.
interface mem_access_if;

    logic        req;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, sel, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, sel, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/mem_access_load_align.sv
// Picks the addressed byte/half out of a big-endian read word and extends it.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [7:0]  aluop_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo_i)
            2'b00:   lane_b = rdata_i[31:24];
            2'b01:   lane_b = rdata_i[23:16];
            2'b10:   lane_b = rdata_i[15:8];
            default: lane_b = rdata_i[7:0];
        endcase
        lane_h = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];

        case (aluop_i)
            AluLb:   data_o = {{24{lane_b[7]}}, lane_b};
            AluLbu:  data_o = {24'h0, lane_b};
            AluLh:   data_o = {{16{lane_h[15]}}, lane_h};
            AluLhu:  data_o = {16'h0, lane_h};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through, or runs a stalling data-bus
// transaction for loads/stores including LL/SC and misalignment detection.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic        mem_cp0_reg_we,
    input  logic [4:0]  mem_cp0_reg_write_addr,
    input  logic [31:0] mem_cp0_reg_data,
    input  logic        flush,
    mem_access_if.master dbus,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        wb_whilo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_cp0_reg_we,
    output logic [4:0]  wb_cp0_reg_write_addr,
    output logic [31:0] wb_cp0_reg_data,
    output logic        stallreq_mem,
    output logic        excep_adel,
    output logic        excep_ades
);

    state_e      state_q, state_d;
    logic        llbit_q, llbit_d;
    logic        kill_q, kill_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  aluop_q, aluop_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic        enter_done, killed;
    logic [31:0] load_data;

    mem_load_align u_load_align (
        .rdata_i   (rdata_q),
        .addr_lo_i (addr_q[1:0]),
        .aluop_i   (aluop_q),
        .data_o    (load_data)
    );

    always_comb begin
        state_d    = state_q;
        llbit_d    = llbit_q;
        kill_d     = kill_q;
        rdata_d    = rdata_q;
        aluop_d    = aluop_q;
        addr_d     = addr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        enter_done = 1'b0;
        killed     = 1'b0;

        dbus.req     = 1'b0;
        dbus.we      = 1'b0;
        dbus.sel     = 4'b0000;
        dbus.addr    = ZeroWord;
        dbus.wdata   = ZeroWord;
        stallreq_mem = NoStop;
        excep_adel   = 1'b0;
        excep_ades   = 1'b0;

        wb_wd                 = mem_wd;
        wb_wreg               = mem_wreg;
        wb_wdata              = mem_wdata;
        wb_whilo              = mem_whilo;
        wb_hi                 = mem_hi;
        wb_lo                 = mem_lo;
        wb_cp0_reg_we         = mem_cp0_reg_we;
        wb_cp0_reg_write_addr = mem_cp0_reg_write_addr;
        wb_cp0_reg_data       = mem_cp0_reg_data;

        unique case (state_q)
            StIdle: begin
                if (is_load(mem_aluop) || is_store(mem_aluop)) begin
                    if (misaligned(mem_aluop, mem_mem_addr[1:0])) begin
                        excep_adel = is_load(mem_aluop);
                        excep_ades = is_store(mem_aluop);
                        wb_wreg    = WriteDisable;
                    end else if (flush) begin
                        wb_wreg = WriteDisable;
                    end else if (mem_aluop == AluSc && !llbit_q) begin
                        wb_wreg  = WriteEnable;
                        wb_wdata = ZeroWord;
                    end else begin
                        aluop_d = mem_aluop;
                        addr_d  = mem_mem_addr;
                        we_d    = is_store(mem_aluop);
                        sel_d   = is_store(mem_aluop) ?
                                  store_sel(mem_aluop, mem_mem_addr[1:0]) : 4'b1111;
                        wdata_d = store_wdata(mem_aluop, mem_reg2);
                        kill_d  = 1'b0;

                        dbus.req     = 1'b1;
                        dbus.we      = we_d;
                        dbus.sel     = sel_d;
                        dbus.addr    = addr_d;
                        dbus.wdata   = wdata_d;
                        stallreq_mem = Stop;
                        wb_wreg      = WriteDisable;

                        if (dbus.ack) begin
                            rdata_d    = dbus.rdata;
                            state_d    = StDone;
                            enter_done = 1'b1;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                // The bus transaction is never abandoned; a flush only marks it dead.
                dbus.req     = 1'b1;
                dbus.we      = we_q;
                dbus.sel     = sel_q;
                dbus.addr    = addr_q;
                dbus.wdata   = wdata_q;
                stallreq_mem = Stop;
                wb_wreg      = WriteDisable;
                if (flush) kill_d = 1'b1;
                if (dbus.ack) begin
                    rdata_d    = dbus.rdata;
                    state_d    = StDone;
                    enter_done = 1'b1;
                    killed     = kill_q || flush;
                end
            end
            StDone: begin
                state_d = StIdle;
                kill_d  = 1'b0;
                if (is_load(aluop_q)) begin
                    wb_wdata = load_data;
                end else if (aluop_q == AluSc) begin
                    wb_wreg  = WriteEnable;
                    wb_wdata = 32'd1;
                end else begin
                    wb_wreg = WriteDisable;
                end
                if (kill_q || flush) begin
                    wb_wreg       = WriteDisable;
                    wb_whilo      = WriteDisable;
                    wb_cp0_reg_we = WriteDisable;
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter_done && !killed) begin
            if (aluop_d == AluLl) llbit_d = 1'b1;
            else if (aluop_d == AluSc) llbit_d = 1'b0;
        end
        if (flush) llbit_d = 1'b0;

        if (resetn) begin
            dbus.req              = 1'b0;
            dbus.we               = 1'b0;
            dbus.sel              = 4'b0000;
            dbus.addr             = ZeroWord;
            dbus.wdata            = ZeroWord;
            stallreq_mem          = NoStop;
            excep_adel            = 1'b0;
            excep_ades            = 1'b0;
            wb_wd                 = NopRegAddr;
            wb_wreg               = WriteDisable;
            wb_wdata              = ZeroWord;
            wb_whilo              = WriteDisable;
            wb_hi                 = ZeroWord;
            wb_lo                 = ZeroWord;
            wb_cp0_reg_we         = WriteDisable;
            wb_cp0_reg_write_addr = NopRegAddr;
            wb_cp0_reg_data       = ZeroWord;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= StIdle;
            llbit_q <= 1'b0;
            kill_q  <= 1'b0;
            rdata_q <= ZeroWord;
            aluop_q <= AluNop;
            addr_q  <= ZeroWord;
            we_q    <= 1'b0;
            sel_q   <= 4'b0000;
            wdata_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            llbit_q <= llbit_d;
            kill_q  <= kill_d;
            rdata_q <= rdata_d;
            aluop_q <= aluop_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for the MEM stage: bus latency, lane handling, LL/SC, faults, flush, reset.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2;
    logic        mem_cp0_reg_we;
    logic [4:0]  mem_cp0_reg_write_addr;
    logic [31:0] mem_cp0_reg_data;
    logic        flush;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi, wb_lo;
    logic        wb_cp0_reg_we;
    logic [4:0]  wb_cp0_reg_write_addr;
    logic [31:0] wb_cp0_reg_data;
    logic        stallreq_mem, excep_adel, excep_ades;

    int checks = 0;
    int errors = 0;

    mem_access_if u_bus ();

    mem_access dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .mem_wd                 (mem_wd),
        .mem_wreg               (mem_wreg),
        .mem_wdata              (mem_wdata),
        .mem_whilo              (mem_whilo),
        .mem_hi                 (mem_hi),
        .mem_lo                 (mem_lo),
        .mem_aluop              (mem_aluop),
        .mem_mem_addr           (mem_mem_addr),
        .mem_reg2               (mem_reg2),
        .mem_cp0_reg_we         (mem_cp0_reg_we),
        .mem_cp0_reg_write_addr (mem_cp0_reg_write_addr),
        .mem_cp0_reg_data       (mem_cp0_reg_data),
        .flush                  (flush),
        .dbus                   (u_bus),
        .wb_wd                  (wb_wd),
        .wb_wreg                (wb_wreg),
        .wb_wdata               (wb_wdata),
        .wb_whilo               (wb_whilo),
        .wb_hi                  (wb_hi),
        .wb_lo                  (wb_lo),
        .wb_cp0_reg_we          (wb_cp0_reg_we),
        .wb_cp0_reg_write_addr  (wb_cp0_reg_write_addr),
        .wb_cp0_reg_data        (wb_cp0_reg_data),
        .stallreq_mem           (stallreq_mem),
        .excep_adel             (excep_adel),
        .excep_ades             (excep_ades)
    );

    always #5 clk = ~clk;

    task automatic set_nop();
        mem_wd = 0; mem_wreg = 0; mem_wdata = 0; mem_whilo = 0; mem_hi = 0; mem_lo = 0;
        mem_aluop = AluNop; mem_mem_addr = 0; mem_reg2 = 0;
        mem_cp0_reg_we = 0; mem_cp0_reg_write_addr = 0; mem_cp0_reg_data = 0;
        flush = 0; u_bus.ack = 0; u_bus.rdata = 0;
    endtask

    task automatic drive_op(input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] reg2, input logic [4:0] wd);
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2; mem_wd = wd; mem_wreg = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        drive_op(AluLw, 32'h100, 32'h0, 5'd3);
        mem_whilo = 1; mem_hi = 32'h1111; mem_cp0_reg_we = 1; u_bus.ack = 1;
        @(negedge clk); #1;
        checks++; if (u_bus.req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", u_bus.req); end
        checks++; if (stallreq_mem !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stallreq_mem); end
        checks++; if ({wb_wreg, wb_whilo, wb_cp0_reg_we} !== 3'b000) begin errors++; $display("FAIL rst_wb_we got %b exp 000", {wb_wreg, wb_whilo, wb_cp0_reg_we}); end
        checks++; if ({wb_wd, wb_wdata, wb_hi} !== 69'h0) begin errors++; $display("FAIL rst_wb_data got %h/%h/%h exp 0", wb_wd, wb_wdata, wb_hi); end
        @(negedge clk);
        resetn = 1'b0;
        set_nop();
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        drive_op(8'h20, 32'h0, 32'h0, 5'd5);
        mem_wdata = 32'h1234_5678; mem_whilo = 1; mem_hi = 32'hAAAA_0000; mem_lo = 32'h5555;
        mem_cp0_reg_we = 1; mem_cp0_reg_write_addr = 5'd9; mem_cp0_reg_data = 32'h77;
        #1;
        checks++; if (wb_wdata !== 32'h1234_5678) begin errors++; $display("FAIL add_wdata got %h exp 12345678", wb_wdata); end
        checks++; if ({wb_wd, wb_wreg} !== {5'd5, 1'b1}) begin errors++; $display("FAIL add_wd got %h/%b exp 05/1", wb_wd, wb_wreg); end
        checks++; if ({wb_whilo, wb_hi, wb_lo} !== {1'b1, 32'hAAAA_0000, 32'h5555}) begin errors++; $display("FAIL add_hilo got %b/%h/%h", wb_whilo, wb_hi, wb_lo); end
        checks++; if ({wb_cp0_reg_we, wb_cp0_reg_write_addr, wb_cp0_reg_data} !== {1'b1, 5'd9, 32'h77}) begin errors++; $display("FAIL add_cp0 got %b/%h/%h", wb_cp0_reg_we, wb_cp0_reg_write_addr, wb_cp0_reg_data); end
        checks++; if ({stallreq_mem, u_bus.req} !== 2'b00) begin errors++; $display("FAIL add_stall got %b exp 00", {stallreq_mem, u_bus.req}); end
        set_nop();
    endtask

    task automatic test_lw_latency();
        int stall_cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) drive_op(AluLw, 32'h100, 32'h0, 5'd3);
            u_bus.ack = (k == 4);
            u_bus.rdata = (k == 4) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (stallreq_mem === 1'b1) stall_cnt++;
            checks++; if ({u_bus.req, u_bus.we, u_bus.addr} !== {2'b10, 32'h100}) begin errors++; $display("FAIL lw_req_c%0d got %b/%b/%h exp 1/0/100", k, u_bus.req, u_bus.we, u_bus.addr); end
        end
        @(negedge clk);
        u_bus.ack = 0; u_bus.rdata = 0;
        #1;
        checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 4", stall_cnt); end
        checks++; if (wb_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_wdata got %h exp deadbeef", wb_wdata); end
        checks++; if ({wb_wreg, wb_wd, stallreq_mem, u_bus.req} !== {1'b1, 5'd3, 2'b00}) begin errors++; $display("FAIL lw_done got %b/%h/%b/%b", wb_wreg, wb_wd, stallreq_mem, u_bus.req); end
        set_nop();
    endtask

    task automatic test_load_lanes();
        logic [7:0]  ops [4] = '{AluLb, AluLbu, AluLh, AluLhu};
        logic [31:0] adr [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] rd  [4] = '{32'h1122_33F0, 32'h1122_33F0, 32'h1234_8001, 32'h8001_1234};
        logic [31:0] exp [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001, 32'h0000_8001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_op(ops[i], adr[i], 32'h0, 5'd8);
            u_bus.ack = 1; u_bus.rdata = rd[i];
            #1;
            checks++; if ({stallreq_mem, u_bus.req} !== 2'b11) begin errors++; $display("FAIL ld%0d_issue got %b exp 11", i, {stallreq_mem, u_bus.req}); end
            @(negedge clk);
            u_bus.ack = 0; u_bus.rdata = 0;
            #1;
            checks++; if ({wb_wdata, stallreq_mem} !== {exp[i], 1'b0}) begin errors++; $display("FAIL ld%0d_data got %h/%b exp %h/0", i, wb_wdata, stallreq_mem, exp[i]); end
            set_nop();
        end
    endtask

    task automatic test_store_lanes();
        logic [7:0]  ops [4] = '{AluSb, AluSh, AluSh, AluSw};
        logic [31:0] adr [4] = '{32'h101, 32'h102, 32'h100, 32'h104};
        logic [31:0] r2  [4] = '{32'h0000_00AB, 32'h0000_1234, 32'h0000_1234, 32'hCAFE_F00D};
        logic [3:0]  sel [4] = '{4'b0100, 4'b0011, 4'b1100, 4'b1111};
        logic [31:0] wd  [4] = '{32'hABAB_ABAB, 32'h1234_1234, 32'h1234_1234, 32'hCAFE_F00D};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_op(ops[i], adr[i], r2[i], 5'd9);
            u_bus.ack = 1;
            #1;
            checks++; if ({u_bus.req, u_bus.we, u_bus.sel} !== {2'b11, sel[i]}) begin errors++; $display("FAIL st%0d_sel got %b/%b/%b exp 1/1/%b", i, u_bus.req, u_bus.we, u_bus.sel, sel[i]); end
            checks++; if ({u_bus.wdata, u_bus.addr} !== {wd[i], adr[i]}) begin errors++; $display("FAIL st%0d_wdata got %h@%h exp %h@%h", i, u_bus.wdata, u_bus.addr, wd[i], adr[i]); end
            @(negedge clk);
            u_bus.ack = 0;
            #1;
            checks++; if ({wb_wreg, stallreq_mem} !== 2'b00) begin errors++; $display("FAIL st%0d_done got %b exp 00", i, {wb_wreg, stallreq_mem}); end
            set_nop();
        end
    endtask

    task automatic test_ll_sc();
        @(negedge clk);
        drive_op(AluLl, 32'h200, 32'h0, 5'd4);
        u_bus.ack = 1; u_bus.rdata = 32'h0BAD_F00D;
        @(negedge clk);
        u_bus.ack = 0; #1;
        checks++; if ({wb_wdata, wb_wreg} !== {32'h0BAD_F00D, 1'b1}) begin errors++; $display("FAIL ll_data got %h/%b", wb_wdata, wb_wreg); end
        set_nop();
        @(negedge clk);
        drive_op(AluSc, 32'h200, 32'h55, 5'd7);
        u_bus.ack = 1; #1;
        checks++; if ({u_bus.req, u_bus.we, u_bus.sel, u_bus.wdata} !== {2'b11, 4'b1111, 32'h55}) begin errors++; $display("FAIL sc1_req got %b/%b/%b/%h", u_bus.req, u_bus.we, u_bus.sel, u_bus.wdata); end
        @(negedge clk);
        u_bus.ack = 0; #1;
        checks++; if ({wb_wdata, wb_wreg, wb_wd} !== {32'd1, 1'b1, 5'd7}) begin errors++; $display("FAIL sc1_done got %h/%b/%h exp 1/1/07", wb_wdata, wb_wreg, wb_wd); end
        @(negedge clk); #1;
        checks++; if ({u_bus.req, stallreq_mem} !== 2'b00) begin errors++; $display("FAIL sc2_noreq got %b exp 00", {u_bus.req, stallreq_mem}); end
        checks++; if ({wb_wdata, wb_wreg} !== {32'd0, 1'b1}) begin errors++; $display("FAIL sc2_fail got %h/%b exp 0/1", wb_wdata, wb_wreg); end
        set_nop();
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        drive_op(AluLw, 32'h102, 32'h0, 5'd2); #1;
        checks++; if ({excep_adel, excep_ades, u_bus.req, wb_wreg, stallreq_mem} !== 5'b10000) begin errors++; $display("FAIL lw_mis got %b exp 10000", {excep_adel, excep_ades, u_bus.req, wb_wreg, stallreq_mem}); end
        @(negedge clk);
        drive_op(AluSw, 32'h201, 32'h1, 5'd2); #1;
        checks++; if ({excep_adel, excep_ades, u_bus.req, stallreq_mem} !== 4'b0100) begin errors++; $display("FAIL sw_mis got %b exp 0100", {excep_adel, excep_ades, u_bus.req, stallreq_mem}); end
        @(negedge clk);
        drive_op(AluSh, 32'h202, 32'h1, 5'd2); u_bus.ack = 1; #1;
        checks++; if ({excep_ades, u_bus.req} !== 2'b01) begin errors++; $display("FAIL sh_aligned got %b exp 01", {excep_ades, u_bus.req}); end
        @(negedge clk);
        set_nop();
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive_op(AluLw, 32'h300, 32'h0, 5'd6); flush = 1; #1;
        checks++; if (u_bus.req !== 1'b0) begin errors++; $display("FAIL flush_idle_req got %b exp 0", u_bus.req); end
        flush = 0; mem_whilo = 1; mem_cp0_reg_we = 1;
        @(negedge clk);
        flush = 1; #1;
        checks++; if ({u_bus.req, u_bus.addr, stallreq_mem} !== {1'b1, 32'h300, 1'b1}) begin errors++; $display("FAIL flush_wait_req got %b/%h/%b", u_bus.req, u_bus.addr, stallreq_mem); end
        @(negedge clk);
        flush = 0; u_bus.ack = 1; u_bus.rdata = 32'h1111_1111; #1;
        checks++; if (u_bus.req !== 1'b1) begin errors++; $display("FAIL flush_held_req got %b exp 1", u_bus.req); end
        @(negedge clk);
        u_bus.ack = 0; #1;
        checks++; if ({wb_wreg, wb_whilo, wb_cp0_reg_we, u_bus.req, stallreq_mem} !== 5'b0) begin errors++; $display("FAIL flush_done_kill got %b exp 00000", {wb_wreg, wb_whilo, wb_cp0_reg_we, u_bus.req, stallreq_mem}); end
        set_nop();
        @(negedge clk);
        drive_op(AluLl, 32'h400, 32'h0, 5'd6);
        @(negedge clk);
        flush = 1; u_bus.ack = 1; #1;
        @(negedge clk);
        flush = 0; u_bus.ack = 0; #1;
        checks++; if (wb_wreg !== 1'b0) begin errors++; $display("FAIL ll_flush_ack got %b exp 0", wb_wreg); end
        set_nop();
        @(negedge clk);
        drive_op(AluSc, 32'h400, 32'h9, 5'd6); #1;
        checks++; if ({u_bus.req, wb_wdata} !== {1'b0, 32'h0}) begin errors++; $display("FAIL ll_flush_nobit got %b/%h exp 0/0", u_bus.req, wb_wdata); end
        set_nop();
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        drive_op(AluLw, 32'h500, 32'h0, 5'd1);
        @(negedge clk); #1;
        checks++; if (u_bus.req !== 1'b1) begin errors++; $display("FAIL rstw_wait got %b exp 1", u_bus.req); end
        @(negedge clk);
        resetn = 1; #1;
        checks++; if (u_bus.req !== 1'b0) begin errors++; $display("FAIL rstw_req got %b exp 0", u_bus.req); end
        @(negedge clk);
        resetn = 0; set_nop(); u_bus.ack = 1; u_bus.rdata = 32'h5A5A_5A5A; #1;
        checks++; if ({u_bus.req, stallreq_mem} !== 2'b00) begin errors++; $display("FAIL rstw_idle got %b exp 00", {u_bus.req, stallreq_mem}); end
        @(negedge clk);
        u_bus.ack = 0; drive_op(8'h20, 32'h0, 32'h0, 5'd2); mem_wdata = 32'h0000_0042; #1;
        checks++; if ({wb_wdata, wb_wreg, stallreq_mem} !== {32'h42, 2'b10}) begin errors++; $display("FAIL rstw_late_ack got %h/%b/%b exp 42/1/0", wb_wdata, wb_wreg, stallreq_mem); end
        set_nop();
    endtask

    initial begin
        set_nop();
        test_reset();
        test_passthrough();
        test_lw_latency();
        test_load_lanes();
        test_store_lanes();
        test_ll_sc();
        test_misaligned();
        test_flush();
        test_reset_mid_wait();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
